cpu_mem_responder: RTL and testbench

CPU_MEM_RESPONDER -- requirements
Module: cpu_mem_responder

---
 rtl/cpu_mem_responder_if.sv | 59 +++++
 rtl/cpu_mem_responder.sv | 157 +++++++++++++++
 tb/tb_cpu_mem_responder.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_mem_responder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_mem_responder_if : CPU fetch/data request bus plus both SRAM ports   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface cpu_mem_responder_if;
    // Instruction request / response
    logic        Inst_Req_Valid;
    logic [31:0] PC;
    logic        Inst_Req_Ack;
    logic [31:0] Instruction;
    logic        Inst_Valid;
    logic        Inst_Ack;

    // Data request / response
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic [3:0]  Write_strb;
    logic        Mem_Req_Ack;
    logic [31:0] Read_data;
    logic        Read_data_Valid;
    logic        Read_data_Ack;

    // Instruction SRAM
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;

    // Data SRAM
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport slave (
        input  Inst_Req_Valid, PC, Inst_Ack,
        input  MemRead, MemWrite, Address, Write_data, Write_strb, Read_data_Ack,
        input  inst_sram_rdata, data_sram_rdata,
        output Inst_Req_Ack, Instruction, Inst_Valid,
        output Mem_Req_Ack, Read_data, Read_data_Valid,
        output inst_sram_en, inst_sram_addr,
        output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
    );

    modport master (
        output Inst_Req_Valid, PC, Inst_Ack,
        output MemRead, MemWrite, Address, Write_data, Write_strb, Read_data_Ack,
        output inst_sram_rdata, data_sram_rdata,
        input  Inst_Req_Ack, Instruction, Inst_Valid,
        input  Mem_Req_Ack, Read_data, Read_data_Valid,
        input  inst_sram_en, inst_sram_addr,
        input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
    );
endinterface

`default_nettype wire

// File: rtl/cpu_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_mem_responder : independent fetch and data responders onto SRAMs     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module cpu_mem_responder #(
    parameter int ACK_DELAY = 0     // extra wait cycles before Ack, 0..15
) (
    input  wire logic          clk,
    input  wire logic          rst,
    cpu_mem_responder_if.slave cpu_bus
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_WAIT  = 2'd1;
    localparam logic [1:0] c_RD    = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;
    localparam logic [3:0] c_DELAY = 4'(ACK_DELAY);

    // ------------------------------------------------------------------
    // Instruction channel
    // ------------------------------------------------------------------
    logic [1:0]  inst_state_q, inst_state_d;
    logic [3:0]  inst_cnt_q,   inst_cnt_d;
    logic [31:0] instr_q,      instr_d;
    logic        w_inst_ack;

    // Ack is withheld if the requester drops the request on the final wait cycle.
    assign w_inst_ack = (inst_state_q == c_WAIT) && (inst_cnt_q == 4'd0)
                        && cpu_bus.Inst_Req_Valid;

    always_comb begin
        inst_state_d = inst_state_q;
        inst_cnt_d   = inst_cnt_q;
        instr_d      = instr_q;
        case (inst_state_q)
            c_IDLE: begin
                if (cpu_bus.Inst_Req_Valid) begin
                    inst_state_d = c_WAIT;
                    inst_cnt_d   = c_DELAY;
                end
            end
            c_WAIT: begin
                if (!cpu_bus.Inst_Req_Valid) begin
                    inst_state_d = c_IDLE;
                    inst_cnt_d   = 4'd0;
                end else if (inst_cnt_q != 4'd0) begin
                    inst_cnt_d   = inst_cnt_q - 4'd1;
                end else begin
                    inst_state_d = c_RD;
                end
            end
            c_RD: begin
                instr_d      = cpu_bus.inst_sram_rdata;
                inst_state_d = c_RESP;
            end
            c_RESP: begin
                if (cpu_bus.Inst_Ack) begin
                    inst_state_d = c_IDLE;
                end
            end
            default: inst_state_d = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_state_q <= c_IDLE;
            inst_cnt_q   <= 4'd0;
            instr_q      <= 32'd0;
        end else begin
            inst_state_q <= inst_state_d;
            inst_cnt_q   <= inst_cnt_d;
            instr_q      <= instr_d;
        end
    end

    assign cpu_bus.Inst_Req_Ack   = w_inst_ack;
    assign cpu_bus.Inst_Valid     = (inst_state_q == c_RESP);
    assign cpu_bus.Instruction    = instr_q;
    assign cpu_bus.inst_sram_en   = w_inst_ack;
    assign cpu_bus.inst_sram_addr = w_inst_ack ? cpu_bus.PC : 32'd0;

    // ------------------------------------------------------------------
    // Data channel
    // ------------------------------------------------------------------
    logic [1:0]  mem_state_q, mem_state_d;
    logic [3:0]  mem_cnt_q,   mem_cnt_d;
    logic [31:0] rdata_q,     rdata_d;
    logic        w_mem_req;
    logic        w_mem_ack;
    logic        w_mem_wr_ack;

    assign w_mem_req    = cpu_bus.MemRead | cpu_bus.MemWrite;
    assign w_mem_ack    = (mem_state_q == c_WAIT) && (mem_cnt_q == 4'd0) && w_mem_req;
    // A write wins over a simultaneous read: no response phase follows.
    assign w_mem_wr_ack = w_mem_ack && cpu_bus.MemWrite;

    always_comb begin
        mem_state_d = mem_state_q;
        mem_cnt_d   = mem_cnt_q;
        rdata_d     = rdata_q;
        case (mem_state_q)
            c_IDLE: begin
                if (w_mem_req) begin
                    mem_state_d = c_WAIT;
                    mem_cnt_d   = c_DELAY;
                end
            end
            c_WAIT: begin
                if (!w_mem_req) begin
                    mem_state_d = c_IDLE;
                    mem_cnt_d   = 4'd0;
                end else if (mem_cnt_q != 4'd0) begin
                    mem_cnt_d   = mem_cnt_q - 4'd1;
                end else if (cpu_bus.MemWrite) begin
                    mem_state_d = c_IDLE;
                end else begin
                    mem_state_d = c_RD;
                end
            end
            c_RD: begin
                rdata_d     = cpu_bus.data_sram_rdata;
                mem_state_d = c_RESP;
            end
            c_RESP: begin
                if (cpu_bus.Read_data_Ack) begin
                    mem_state_d = c_IDLE;
                end
            end
            default: mem_state_d = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_state_q <= c_IDLE;
            mem_cnt_q   <= 4'd0;
            rdata_q     <= 32'd0;
        end else begin
            mem_state_q <= mem_state_d;
            mem_cnt_q   <= mem_cnt_d;
            rdata_q     <= rdata_d;
        end
    end

    assign cpu_bus.Mem_Req_Ack     = w_mem_ack;
    assign cpu_bus.Read_data_Valid = (mem_state_q == c_RESP);
    assign cpu_bus.Read_data       = rdata_q;
    assign cpu_bus.data_sram_en    = w_mem_ack;
    assign cpu_bus.data_sram_addr  = w_mem_ack ? cpu_bus.Address : 32'd0;
    assign cpu_bus.data_sram_wen   = w_mem_wr_ack ? cpu_bus.Write_strb : 4'd0;
    assign cpu_bus.data_sram_wdata = w_mem_wr_ack ? cpu_bus.Write_data : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_cpu_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cpu_mem_responder : three delay variants against a timestamp model    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_cpu_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_ack, mem_rd, mem_wr, rd_ack;
    logic [31:0] pc, addr, wdata;
    logic [3:0]  strb;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] ifun(input logic [31:0] a);
        return (a == 32'hBFC0_0000) ? 32'h2408_0001 : (a ^ 32'h1357_9BDF);
    endfunction

    function automatic logic [31:0] dfun(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    for (genvar G = 0; G < 3; G++) begin : g_dut
        localparam int D = (G == 0) ? 0 : ((G == 1) ? 3 : 2);

        cpu_mem_responder_if bus ();

        assign bus.Inst_Req_Valid = inst_req;
        assign bus.PC             = pc;
        assign bus.Inst_Ack       = inst_ack;
        assign bus.MemRead        = mem_rd;
        assign bus.MemWrite       = mem_wr;
        assign bus.Address        = addr;
        assign bus.Write_data     = wdata;
        assign bus.Write_strb     = strb;
        assign bus.Read_data_Ack  = rd_ack;

        cpu_mem_responder #(.ACK_DELAY(D)) dut (
            .clk     (clk),
            .rst     (rst),
            .cpu_bus (bus)
        );

        always @(posedge clk) begin
            if (bus.inst_sram_en) bus.inst_sram_rdata <= ifun(bus.inst_sram_addr);
            if (bus.data_sram_en) bus.data_sram_rdata <= dfun(bus.data_sram_addr);
        end

        // Model: a request seen at cycle s is acked at s+1+D if still present,
        // and a read response appears two cycles after its ack.
        int          cyc = 0, i_seen = 0, i_rstart = 0, d_seen = 0, d_rstart = 0;
        bit          armed = 0, i_busy = 0, i_resp = 0, d_busy = 0, d_resp = 0;
        logic [31:0] i_val = 0, d_val = 0, i_addr = 0, d_addr = 0;
        logic        e_iack, e_mack;

        initial forever begin
            @(posedge clk);
            if (rst) begin
                armed = 1; i_busy = 0; i_resp = 0; d_busy = 0; d_resp = 0;
                i_val = 0; d_val = 0;
            end else begin
                if (i_resp) begin
                    if (cyc < i_rstart) i_val = ifun(i_addr);
                    else if (inst_ack) i_resp = 0;
                end else if (i_busy) begin
                    if (!inst_req) i_busy = 0;
                    else if (cyc == i_seen + 1 + D) begin
                        i_busy = 0; i_resp = 1; i_rstart = cyc + 2; i_addr = pc;
                    end
                end else if (inst_req) begin
                    i_busy = 1; i_seen = cyc;
                end

                if (d_resp) begin
                    if (cyc < d_rstart) d_val = dfun(d_addr);
                    else if (rd_ack) d_resp = 0;
                end else if (d_busy) begin
                    if (!(mem_rd || mem_wr)) d_busy = 0;
                    else if (cyc == d_seen + 1 + D) begin
                        d_busy = 0;
                        if (!mem_wr) begin
                            d_resp = 1; d_rstart = cyc + 2; d_addr = addr;
                        end
                    end
                end else if (mem_rd || mem_wr) begin
                    d_busy = 1; d_seen = cyc;
                end
            end
            cyc++;
        end

        initial forever begin
            @(negedge clk);
            if (armed) begin
                e_iack = i_busy && (cyc == i_seen + 1 + D) && inst_req;
                e_mack = d_busy && (cyc == d_seen + 1 + D) && (mem_rd || mem_wr);
                chk1($sformatf("g%0d_Inst_Req_Ack@%0d", G, cyc), bus.Inst_Req_Ack, e_iack);
                chk1($sformatf("g%0d_inst_sram_en@%0d", G, cyc), bus.inst_sram_en, e_iack);
                if (e_iack) chk32($sformatf("g%0d_inst_sram_addr@%0d", G, cyc), bus.inst_sram_addr, pc);
                chk1($sformatf("g%0d_Inst_Valid@%0d", G, cyc), bus.Inst_Valid, i_resp && (cyc >= i_rstart));
                chk32($sformatf("g%0d_Instruction@%0d", G, cyc), bus.Instruction, i_val);
                chk1($sformatf("g%0d_Mem_Req_Ack@%0d", G, cyc), bus.Mem_Req_Ack, e_mack);
                chk1($sformatf("g%0d_data_sram_en@%0d", G, cyc), bus.data_sram_en, e_mack);
                chk32($sformatf("g%0d_data_sram_wen@%0d", G, cyc), 32'(bus.data_sram_wen),
                      (e_mack && mem_wr) ? 32'(strb) : 32'd0);
                if (e_mack) chk32($sformatf("g%0d_data_sram_addr@%0d", G, cyc), bus.data_sram_addr, addr);
                if (e_mack && mem_wr)
                    chk32($sformatf("g%0d_data_sram_wdata@%0d", G, cyc), bus.data_sram_wdata, wdata);
                chk1($sformatf("g%0d_Read_data_Valid@%0d", G, cyc), bus.Read_data_Valid,
                     d_resp && (cyc >= d_rstart));
                chk32($sformatf("g%0d_Read_data@%0d", G, cyc), bus.Read_data, d_val);
            end
        end
    end

    // Leaves every instance idle; returns at the start of a fresh cycle.
    task automatic settle(input int n);
        @(posedge clk); #1;
        inst_req = 0; mem_rd = 0; mem_wr = 0; strb = 0; inst_ack = 1; rd_ack = 1;
        repeat (n) @(posedge clk);
        #1;
        inst_ack = 0; rd_ack = 0;
    endtask

    initial begin
        rst = 1; inst_req = 0; inst_ack = 0; mem_rd = 0; mem_wr = 0; rd_ack = 0;
        pc = 0; addr = 0; wdata = 0; strb = 0;
        repeat (3) @(posedge clk);
        #1; rst = 0;
        @(negedge clk);
        chk32("rst_Instruction", g_dut[0].bus.Instruction, 32'd0);
        chk32("rst_Read_data", g_dut[0].bus.Read_data, 32'd0);
        chk1("rst_Inst_Valid", g_dut[0].bus.Inst_Valid, 1'b0);
        chk1("rst_Read_data_Valid", g_dut[0].bus.Read_data_Valid, 1'b0);

        // Fetch with zero delay, response held until Inst_Ack
        @(posedge clk); #1; inst_req = 1; pc = 32'hBFC0_0000;
        @(negedge clk); chk1("A_ack_c0", g_dut[0].bus.Inst_Req_Ack, 1'b0);
        @(negedge clk); chk1("A_ack_c1", g_dut[0].bus.Inst_Req_Ack, 1'b1);
        chk1("A_en_c1", g_dut[0].bus.inst_sram_en, 1'b1);
        chk32("A_addr_c1", g_dut[0].bus.inst_sram_addr, 32'hBFC0_0000);
        @(negedge clk); chk1("A_valid_c2", g_dut[0].bus.Inst_Valid, 1'b0);
        @(negedge clk); chk1("A_valid_c3", g_dut[0].bus.Inst_Valid, 1'b1);
        chk32("A_instr_c3", g_dut[0].bus.Instruction, 32'h2408_0001);
        repeat (3) @(negedge clk);
        chk1("A_valid_c6", g_dut[0].bus.Inst_Valid, 1'b1);
        chk32("A_instr_c6", g_dut[0].bus.Instruction, 32'h2408_0001);
        @(posedge clk); #1; inst_ack = 1; inst_req = 0;
        @(negedge clk); chk1("A_valid_c7", g_dut[0].bus.Inst_Valid, 1'b1);
        @(posedge clk); #1; inst_ack = 0;
        @(negedge clk); chk1("A_valid_c8", g_dut[0].bus.Inst_Valid, 1'b0);
        chk32("A_instr_kept", g_dut[0].bus.Instruction, 32'h2408_0001);

        // Back-to-back fetch: next ack two cycles after the handshake
        settle(8);
        inst_ack = 1; inst_req = 1; pc = 32'h0000_1000;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 1) chk1("G_ack_c1", g_dut[0].bus.Inst_Req_Ack, 1'b1);
            if (c == 3) begin
                chk1("G_valid_c3", g_dut[0].bus.Inst_Valid, 1'b1);
                chk32("G_instr_c3", g_dut[0].bus.Instruction, 32'h1357_8BDF);
            end
            if (c == 4) chk1("G_ack_c4", g_dut[0].bus.Inst_Req_Ack, 1'b0);
            if (c == 5) chk1("G_ack_c5", g_dut[0].bus.Inst_Req_Ack, 1'b1);
        end

        // Delayed write on the ACK_DELAY=3 instance
        settle(8);
        mem_wr = 1; addr = 32'h100; wdata = 32'hDEAD_BEEF; strb = 4'h3;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            chk1($sformatf("B_ack_c%0d", c), g_dut[1].bus.Mem_Req_Ack, c == 4);
            if (c == 4) chk32("B_wen_c4", 32'(g_dut[1].bus.data_sram_wen), 32'h3);
        end
        @(posedge clk); #1; mem_wr = 0; strb = 0;
        @(negedge clk); chk1("B_ack_c5", g_dut[1].bus.Mem_Req_Ack, 1'b0);
        chk1("B_no_valid", g_dut[1].bus.Read_data_Valid, 1'b0);

        // Read response stalled ten cycles by the requester
        settle(8);
        mem_rd = 1; addr = 32'h200;
        @(posedge clk); #1;
        @(posedge clk); #1; mem_rd = 0;
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk1($sformatf("C_valid_%0d", k), g_dut[0].bus.Read_data_Valid, 1'b1);
            chk32($sformatf("C_data_%0d", k), g_dut[0].bus.Read_data, 32'h0200_FDFF);
        end
        @(posedge clk); #1; rd_ack = 1;
        @(negedge clk); chk1("C_valid_hs", g_dut[0].bus.Read_data_Valid, 1'b1);
        @(posedge clk); #1; rd_ack = 0;
        @(negedge clk); chk1("C_valid_after", g_dut[0].bus.Read_data_Valid, 1'b0);
        chk32("C_data_kept", g_dut[0].bus.Read_data, 32'h0200_FDFF);

        // Read abandoned during the wait on the ACK_DELAY=2 instance
        settle(8);
        rd_ack = 1; mem_rd = 1; addr = 32'h300;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk1($sformatf("D_ack_c%0d", c), g_dut[2].bus.Mem_Req_Ack, 1'b0);
            chk1($sformatf("D_en_c%0d", c), g_dut[2].bus.data_sram_en, 1'b0);
            if (c == 1) begin
                @(posedge clk); #1; mem_rd = 0;
            end
        end

        // Read and write together, zero strobe: acked as a write, no response
        settle(8);
        mem_rd = 1; mem_wr = 1; strb = 4'h0; addr = 32'h500; wdata = 32'h1234_5678;
        @(negedge clk);
        @(negedge clk); chk1("F_ack_c1", g_dut[0].bus.Mem_Req_Ack, 1'b1);
        chk1("F_en_c1", g_dut[0].bus.data_sram_en, 1'b1);
        chk32("F_wen_c1", 32'(g_dut[0].bus.data_sram_wen), 32'h0);
        chk32("F_addr_c1", g_dut[0].bus.data_sram_addr, 32'h500);
        @(posedge clk); #1; mem_rd = 0; mem_wr = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk1($sformatf("F_no_valid_%0d", c), g_dut[0].bus.Read_data_Valid, 1'b0);
        end

        // Concurrent fetch and load, reset while both are reading
        settle(8);
        inst_req = 1; pc = 32'h0040_0000; mem_rd = 1; addr = 32'h400;
        @(negedge clk);
        @(negedge clk); chk1("E_iack_c1", g_dut[0].bus.Inst_Req_Ack, 1'b1);
        chk1("E_mack_c1", g_dut[0].bus.Mem_Req_Ack, 1'b1);
        @(posedge clk); #1; rst = 1; inst_req = 0; mem_rd = 0;
        @(negedge clk);
        @(posedge clk); #1; rst = 0;
        @(negedge clk);
        chk32("E_instr_zero", g_dut[0].bus.Instruction, 32'd0);
        chk32("E_rdata_zero", g_dut[0].bus.Read_data, 32'd0);
        chk1("E_ival_zero", g_dut[0].bus.Inst_Valid, 1'b0);
        chk1("E_dval_zero", g_dut[0].bus.Read_data_Valid, 1'b0);
        chk1("E_ien_zero", g_dut[0].bus.inst_sram_en, 1'b0);
        chk1("E_den_zero", g_dut[0].bus.data_sram_en, 1'b0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk1($sformatf("E_no_ival_%0d", c), g_dut[0].bus.Inst_Valid, 1'b0);
            chk1($sformatf("E_no_dval_%0d", c), g_dut[0].bus.Read_data_Valid, 1'b0);
        end

        settle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
